// File: rtl/team_08_cactus_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : team_08_cactus_generator_pkg
// Description : Shared team_08 game definitions: game state encoding, screen
//               and cactus geometry, and the cactus height table used by the
//               obstacle generator, collision detector and sprite renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package team_08_cactus_generator_pkg;

    // Game state produced by the game FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2,
        WIN  = 2'd3
    } state_t;

    localparam int unsigned CACTUS_WIDTH = 20;
    localparam int unsigned SCREEN_W     = 320;

    localparam logic [8:0] H_SHORT = 9'd30;
    localparam logic [8:0] H_MED   = 9'd40;
    localparam logic [8:0] H_TALL  = 9'd50;
    localparam logic [8:0] H_GIANT = 9'd60;

    // Index 0..3 -> SHORT, MED, TALL, GIANT (packed: element 0 is rightmost).
    localparam logic [3:0][8:0] HEIGHT_TABLE = {H_GIANT, H_TALL, H_MED, H_SHORT};

    function automatic logic [8:0] height_lookup(input logic [1:0] i_idx);
        return HEIGHT_TABLE[i_idx];
    endfunction

endpackage : team_08_cactus_generator_pkg
`default_nettype wire

// File: rtl/team_08_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : team_08_lfsr16
// Description : 16-bit Fibonacci LFSR, taps 16,14,13,11 (maximal length).
//               Shifts left every cycle; loads SEED on synchronous reset.
//               A non-zero seed guarantees the value never reaches zero.
// Ports       : clk     - system clock
//               reset   - synchronous active-high reset
//               o_value - current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module team_08_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] o_value
);

    logic [15:0] r_lfsr;
    logic        w_feedback;

    // Tap positions 16,14,13,11 map to bits 15,13,12,10.
    assign w_feedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_feedback};
        end
    end

    assign o_value = r_lfsr;

endmodule : team_08_lfsr16
`default_nettype wire

// File: rtl/team_08_cactus_generator.sv
`default_nettype none
// ============================================================================
// Module      : team_08_cactus_generator
// Description : Scrolling two-cactus obstacle stream. On each frame tick in
//               RUN the pair moves left by the effective speed; when the
//               leading cactus would leave the screen the trailing one is
//               promoted and a new trailing cactus is drawn from the LFSR.
// Ports       : clk            - system clock
//               reset          - synchronous active-high reset
//               state          - game state from the game FSM
//               move_tick      - one-cycle frame strobe
//               speed          - pixels per tick (0 behaves as 1)
//               cactusX1       - leading cactus X position
//               cactusRandDist - gap from leading to trailing cactus
//               cactusHeight1  - leading cactus height
//               cactusHeight2  - trailing cactus height
//               cactus_passed  - one-cycle pulse on each promotion
// Revision    : 1.0 - initial release
// ============================================================================
module team_08_cactus_generator
    import team_08_cactus_generator_pkg::*;
#(
    parameter int unsigned SPAWN_X   = 320,
    parameter int unsigned INIT_DIST = 96,
    parameter int unsigned MIN_DIST  = 60,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  state_t     state,
    input  logic       move_tick,
    input  logic [2:0] speed,
    output logic [8:0] cactusX1,
    output logic [8:0] cactusRandDist,
    output logic [8:0] cactusHeight1,
    output logic [8:0] cactusHeight2,
    output logic       cactus_passed
);

    localparam logic [8:0] C_SPAWN_X   = 9'(SPAWN_X);
    localparam logic [8:0] C_INIT_DIST = 9'(INIT_DIST);
    localparam logic [8:0] C_MIN_DIST  = 9'(MIN_DIST);

    logic [15:0] w_lfsr;
    logic [8:0]  w_spd_eff;
    logic        w_promote;
    logic [8:0]  w_promote_x;
    logic [8:0]  w_new_gap;
    logic [8:0]  w_new_height;
    logic        w_unused_lfsr;

    logic [8:0]  r_x1;
    logic [8:0]  r_gap;
    logic [8:0]  r_h1;
    logic [8:0]  r_h2;
    logic        r_passed;

    team_08_lfsr16 #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .o_value (w_lfsr)
    );

    // Only the low byte feeds obstacle selection.
    assign w_unused_lfsr = &{1'b0, w_lfsr[15:8]};

    assign w_spd_eff = (speed == 3'd0) ? 9'd1 : {6'd0, speed};
    assign w_promote = (r_x1 < w_spd_eff);

    // Sum formed at 10 bits; fits in 9 because the gap always exceeds speed.
    assign w_promote_x  = 9'(({1'b0, r_x1} + {1'b0, r_gap}) - {1'b0, w_spd_eff});
    assign w_new_gap    = C_MIN_DIST + {3'd0, w_lfsr[7:2]};
    assign w_new_height = height_lookup(w_lfsr[1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x1     <= C_SPAWN_X;
            r_gap    <= C_INIT_DIST;
            r_h1     <= H_TALL;
            r_h2     <= H_SHORT;
            r_passed <= 1'b0;
        end else begin
            r_passed <= 1'b0;
            case (state)
                IDLE: begin
                    r_x1  <= C_SPAWN_X;
                    r_gap <= C_INIT_DIST;
                    r_h1  <= H_TALL;
                    r_h2  <= H_SHORT;
                end
                RUN: begin
                    if (move_tick) begin
                        if (w_promote) begin
                            r_x1     <= w_promote_x;
                            r_gap    <= w_new_gap;
                            r_h1     <= r_h2;
                            r_h2     <= w_new_height;
                            r_passed <= 1'b1;
                        end else begin
                            r_x1 <= r_x1 - w_spd_eff;
                        end
                    end
                end
                default: begin
                    // OVER / WIN: positions and heights frozen.
                end
            endcase
        end
    end

    assign cactusX1       = r_x1;
    assign cactusRandDist = r_gap;
    assign cactusHeight1  = r_h1;
    assign cactusHeight2  = r_h2;
    assign cactus_passed  = r_passed;

endmodule : team_08_cactus_generator
`default_nettype wire

// File: tb/tb_team_08_cactus_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_team_08_cactus_generator
// Description : Self-checking bench for team_08_cactus_generator. Expected
//               outputs are pushed to a queue as each cycle is driven and
//               popped/compared after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_team_08_cactus_generator;
    import team_08_cactus_generator_pkg::*;

    logic       clk;
    logic       reset;
    state_t     state;
    logic       move_tick;
    logic [2:0] speed;
    logic [8:0] cactusX1;
    logic [8:0] cactusRandDist;
    logic [8:0] cactusHeight1;
    logic [8:0] cactusHeight2;
    logic       cactus_passed;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_x, m_gap, m_h1, m_h2;
    logic        m_p;
    logic [15:0] m_lfsr;
    int          tbl [4] = '{30, 40, 50, 60};
    logic [36:0] sbq [$];

    team_08_cactus_generator dut (
        .clk            (clk),
        .reset          (reset),
        .state          (state),
        .move_tick      (move_tick),
        .speed          (speed),
        .cactusX1       (cactusX1),
        .cactusRandDist (cactusRandDist),
        .cactusHeight1  (cactusHeight1),
        .cactusHeight2  (cactusHeight2),
        .cactus_passed  (cactus_passed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent LFSR model: x^16+x^14+x^13+x^11+1, shift left.
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [36:0] obs();
        return {cactusX1, cactusRandDist, cactusHeight1, cactusHeight2, cactus_passed};
    endfunction

    // Drive one cycle from a negedge, push the expected post-edge outputs,
    // and return at the following negedge.
    task automatic drive(input state_t st, input logic tick, input logic [2:0] spd, input logic rst);
        int s;
        reset = rst; state = st; move_tick = tick; speed = spd;
        m_p = 1'b0;
        if (rst || st == IDLE) begin
            m_x = 320; m_gap = 96; m_h1 = 50; m_h2 = 30;
        end else if (st == RUN && tick) begin
            s = (spd == 3'd0) ? 1 : int'(spd);
            if (m_x >= s) begin
                m_x = m_x - s;
            end else begin
                m_x   = m_x + m_gap - s;
                m_gap = 60 + int'(m_lfsr[7:2]);
                m_h1  = m_h2;
                m_h2  = tbl[m_lfsr[1:0]];
                m_p   = 1'b1;
            end
        end
        sbq.push_back({9'(m_x), 9'(m_gap), 9'(m_h1), 9'(m_h2), m_p});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [36:0] e;
        for (int i = 0; i < 3; i++) begin
            drive(IDLE, 1'b0, 3'd0, 1'b1);
            e = sbq.pop_front(); total++;
            if (obs() !== e) begin bad++; $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs(), e); end
        end
        total++;
        if (dut.u_lfsr.o_value !== 16'hACE1) begin
            bad++; $display("FAIL reset_lfsr got=%h exp=%h", dut.u_lfsr.o_value, 16'hACE1);
        end
    endtask

    task automatic test_idle();
        logic [36:0] e;
        for (int i = 0; i < 10; i++) begin
            drive(IDLE, logic'(i % 2), 3'd5, 1'b0);
            e = sbq.pop_front(); total++;
            if (obs() !== e || obs() !== {9'd320, 9'd96, 9'd50, 9'd30, 1'b0}) begin
                bad++; $display("FAIL idle cyc=%0d got=%h exp=%h", i, obs(), e);
            end
        end
    endtask

    task automatic test_scroll();
        logic [36:0] e;
        drive(RUN, 1'b0, 3'd3, 1'b0);
        e = sbq.pop_front(); total++;
        if (cactusX1 !== 9'd320 || obs() !== e) begin bad++; $display("FAIL scroll_hold0 got=%h exp=%h", obs(), e); end
        for (int k = 0; k < 5; k++) begin
            drive(RUN, 1'b1, 3'd3, 1'b0);
            e = sbq.pop_front(); total++;
            if (obs() !== e || cactusX1 !== 9'(317 - 3 * k)) begin
                bad++; $display("FAIL scroll_tick k=%0d got=%h exp=%h", k, obs(), e);
            end
            drive(RUN, 1'b0, 3'd3, 1'b0);
            e = sbq.pop_front(); total++;
            if (obs() !== e || cactusX1 !== 9'(317 - 3 * k)) begin
                bad++; $display("FAIL scroll_hold k=%0d got=%h exp=%h", k, obs(), e);
            end
        end
    endtask

    task automatic test_speed0();
        logic [36:0] e;
        drive(IDLE, 1'b0, 3'd0, 1'b0);
        e = sbq.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL speed0_reload got=%h exp=%h", obs(), e); end
        for (int k = 0; k < 4; k++) begin
            drive(RUN, 1'b1, 3'd0, 1'b0);
            e = sbq.pop_front(); total++;
            if (obs() !== e || cactusX1 !== 9'(319 - k)) begin
                bad++; $display("FAIL speed0 k=%0d got=%h exp=%h", k, obs(), e);
            end
        end
    endtask

    task automatic test_promote();
        logic [36:0] e;
        logic [8:0]  old_h2;
        drive(IDLE, 1'b0, 3'd0, 1'b0);
        e = sbq.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL promote_reload got=%h exp=%h", obs(), e); end
        for (int k = 0; k < 53; k++) begin
            drive(RUN, 1'b1, 3'd6, 1'b0);
            e = sbq.pop_front(); total++;
            if (obs() !== e) begin bad++; $display("FAIL promote_approach k=%0d got=%h exp=%h", k, obs(), e); end
        end
        total++;
        if (cactusX1 !== 9'd2) begin bad++; $display("FAIL promote_at2 got=%0d exp=2", cactusX1); end
        old_h2 = cactusHeight2;
        drive(RUN, 1'b1, 3'd5, 1'b0);
        e = sbq.pop_front(); total++;
        if (obs() !== e) begin bad++; $display("FAIL promote_edge got=%h exp=%h", obs(), e); end
        total++;
        if (cactusX1 !== 9'd93 || cactusHeight1 !== old_h2 || cactus_passed !== 1'b1) begin
            bad++; $display("FAIL promote_fields got x=%0d h1=%0d p=%0d exp x=93 h1=%0d p=1",
                            cactusX1, cactusHeight1, cactus_passed, old_h2);
        end
        total++;
        if (cactusRandDist < 9'd60 || cactusRandDist > 9'd123 ||
            !(cactusHeight2 inside {9'd30, 9'd40, 9'd50, 9'd60})) begin
            bad++; $display("FAIL promote_range got gap=%0d h2=%0d exp gap 60..123 h2 in 30/40/50/60",
                            cactusRandDist, cactusHeight2);
        end
        drive(RUN, 1'b0, 3'd5, 1'b0);
        e = sbq.pop_front(); total++;
        if (obs() !== e || cactus_passed !== 1'b0) begin
            bad++; $display("FAIL promote_pulse_end got=%h exp=%h", obs(), e);
        end
    endtask

    // Tick every cycle through at least one further promotion.
    task automatic test_back_to_back();
        logic [36:0] e;
        int          pulses = 0;
        for (int k = 0; k < 30; k++) begin
            drive(RUN, 1'b1, 3'd7, 1'b0);
            e = sbq.pop_front(); total++;
            if (obs() !== e) begin bad++; $display("FAIL b2b k=%0d got=%h exp=%h", k, obs(), e); end
            if (cactus_passed === 1'b1) pulses++;
        end
        total++;
        if (pulses < 1) begin bad++; $display("FAIL b2b_pulses got=%0d exp>=1", pulses); end
    endtask

    task automatic test_freeze();
        logic [36:0] e;
        logic [36:0] snap;
        snap = obs();
        for (int k = 0; k < 10; k++) begin
            drive(OVER, 1'b1, 3'd6, 1'b0);
            e = sbq.pop_front(); total++;
            if (obs() !== e || obs() !== {snap[36:1], 1'b0}) begin
                bad++; $display("FAIL freeze_over k=%0d got=%h exp=%h", k, obs(), e);
            end
        end
        for (int k = 0; k < 3; k++) begin
            drive(WIN, 1'b1, 3'd2, 1'b0);
            e = sbq.pop_front(); total++;
            if (obs() !== e) begin bad++; $display("FAIL freeze_win k=%0d got=%h exp=%h", k, obs(), e); end
        end
        drive(IDLE, 1'b1, 3'd2, 1'b0);
        e = sbq.pop_front(); total++;
        if (obs() !== e || obs() !== {9'd320, 9'd96, 9'd50, 9'd30, 1'b0}) begin
            bad++; $display("FAIL freeze_reload got=%h exp=%h", obs(), e);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [36:0] e;
        for (int k = 0; k < 45; k++) begin
            drive(RUN, 1'b1, 3'd7, 1'b0);
            e = sbq.pop_front(); total++;
            if (obs() !== e) begin bad++; $display("FAIL rstrun_approach k=%0d got=%h exp=%h", k, obs(), e); end
        end
        drive(RUN, 1'b1, 3'd4, 1'b0);
        e = sbq.pop_front(); total++;
        if (obs() !== e || cactusX1 !== 9'd1) begin bad++; $display("FAIL rstrun_at1 got=%h exp=%h", obs(), e); end
        drive(RUN, 1'b1, 3'd3, 1'b1);
        e = sbq.pop_front(); total++;
        if (obs() !== e || obs() !== {9'd320, 9'd96, 9'd50, 9'd30, 1'b0}) begin
            bad++; $display("FAIL rstrun_values got=%h exp=%h", obs(), e);
        end
        total++;
        if (dut.u_lfsr.o_value !== 16'hACE1) begin
            bad++; $display("FAIL rstrun_lfsr got=%h exp=%h", dut.u_lfsr.o_value, 16'hACE1);
        end
        drive(RUN, 1'b0, 3'd3, 1'b0);
        e = sbq.pop_front(); total++;
        if (obs() !== e || cactus_passed !== 1'b0) begin bad++; $display("FAIL rstrun_after got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_lfsr_long();
        reset = 1'b0; state = RUN; move_tick = 1'b0; speed = 3'd1;
        for (int k = 0; k < 70000; k++) begin
            @(negedge clk);
            total++;
            if (dut.u_lfsr.o_value !== m_lfsr || dut.u_lfsr.o_value === 16'h0000) begin
                bad++; $display("FAIL lfsr_seq cyc=%0d got=%h exp=%h (nonzero)", k, dut.u_lfsr.o_value, m_lfsr);
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b1; state = IDLE; move_tick = 1'b0; speed = 3'd0;
        m_x = 320; m_gap = 96; m_h1 = 50; m_h2 = 30; m_p = 1'b0;
        @(negedge clk);
        test_reset();
        test_idle();
        test_scroll();
        test_speed0();
        test_promote();
        test_back_to_back();
        test_freeze();
        test_reset_mid_run();
        test_lfsr_long();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_team_08_cactus_generator
`default_nettype wire

// File: doc/team_08_cactus_generator.md
Name: team_08_cactus_generator

Overview:
Producer end of the obstacle interface consumed by the team_08 collision detector and the sprite renderer. It generates a scrolling stream of two cacti: the leading cactus X position, the gap to the trailing cactus, and one height per cactus. On each frame tick during RUN the pair scrolls left by the current speed. When the leading cactus leaves the screen, the trailing cactus is promoted to leading and a new trailing cactus is drawn from an LFSR.

Parameters:
SPAWN_X, 320, X position loaded into cactusX1 at reset and while in IDLE (screen width).
INIT_DIST, 96, cactusRandDist loaded at reset and while in IDLE.
MIN_DIST, 60, minimum gap between the two cacti; must exceed the maximum speed (7).
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
state  input  state_t  game state (IDLE, RUN, OVER, WIN) from the game FSM
move_tick  input  1  one-cycle frame strobe; scroll step enable
speed  input  3  pixels per tick; value 0 is treated as 1
cactusX1  output  9  leading cactus X position, registered
cactusRandDist  output  9  gap from leading to trailing cactus (cactusX2 = cactusX1 + cactusRandDist), registered
cactusHeight1  output  9  leading cactus height, registered
cactusHeight2  output  9  trailing cactus height, registered
cactus_passed  output  1  one-cycle pulse on each promotion (score increment)

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high. All outputs are registered and all updates take effect on the clk edge.
- Reset values:
  - cactusX1 = SPAWN_X, cactusRandDist = INIT_DIST.
  - cactusHeight1 = H_TALL, cactusHeight2 = H_SHORT.
  - cactus_passed = 0, lfsr = LFSR_SEED.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, shifts left every clk cycle in every state except during reset.
  - Free-running, so obstacle sequences depend on player timing.
  - It never reaches zero.
- spd_eff = (speed == 0) ? 1 : speed. This is zero-extended to 9 bits for all arithmetic.
- Internal mode is derived from state (no extra FSM register beyond the outputs):
  - IDLE: every cycle, reload cactusX1, cactusRandDist and both heights to their reset values. cactus_passed = 0. move_tick is ignored.
  - RUN, move_tick = 0: hold all outputs; cactus_passed = 0.
  - RUN, move_tick = 1, cactusX1 >= spd_eff (scroll): cactusX1 <= cactusX1 - spd_eff. Gap and heights hold. cactus_passed = 0.
  - RUN, move_tick = 1, cactusX1 < spd_eff (promote), all updated in the same edge:
    - cactusX1 <= cactusX1 + cactusRandDist - spd_eff.
    - cactusRandDist <= MIN_DIST + lfsr[7:2], range 60..123.
    - cactusHeight1 <= cactusHeight2.
    - cactusHeight2 <= HEIGHT_TABLE[lfsr[1:0]].
    - cactus_passed <= 1 for exactly one cycle.
  - OVER, WIN: freeze all position and height outputs; cactus_passed = 0; move_tick is ignored.
- Width and overflow:
  - cactusX1 + cactusRandDist + CACTUS_WIDTH <= 320 + 123 + 20 = 463 < 512, so the 9-bit sum in the detector never wraps.
  - The promote sum is computed at 10 bits and then truncated. The result is always < 512 because MIN_DIST > spd_eff.
- Simultaneous events:
  - reset beats everything.
  - A state change and move_tick in the same cycle act on the current-cycle `state` value only.
  - Reset asserted mid-RUN returns all outputs, including the LFSR, to reset values on the next edge.
- Latency: one cycle from move_tick to updated outputs.

Decomposition:
- Shared team_08 package contains:
  - state_t, already used by the collision detector.
  - CACTUS_WIDTH = 20, SCREEN_W = 320.
  - H_SHORT = 30, H_MED = 40, H_TALL = 50, H_GIANT = 60.
  - HEIGHT_TABLE mapping index 0..3 to those heights in that order.
- One natural sub-module: team_08_lfsr16 (clk, reset, seed parameter, 16-bit value out), reusable for other random game elements.

Test Plan:
1. Reset, then hold state = IDLE for 10 cycles with move_tick pulsing -> cactusX1 = 320, cactusRandDist = 96, heights 50/30, cactus_passed = 0 throughout.
2. state = RUN, speed = 3, 5 move_ticks -> cactusX1 = 320, 317, 314, 311, 308, 305, each updating one cycle after its tick; no update on non-tick cycles.
3. RUN, speed = 0, 4 ticks -> cactusX1 decreases by 1 per tick (320 to 316).
4. RUN, cactusX1 = 2, gap = 96, speed = 5, tick -> cactusX1 = 93, cactusHeight1 = old cactusHeight2, gap in 60..123, cactusHeight2 in {30,40,50,60}, cactus_passed high for exactly 1 cycle.
5. RUN mid-scroll (cactusX1 = 200), switch state to OVER, 10 ticks -> all outputs frozen at 200 and the existing gap/heights; then IDLE -> reload to 320/96/50/30 on the next edge.
6. Reset asserted during a RUN tick at cactusX1 = 1 -> no promotion and no cactus_passed pulse; outputs at reset values; LFSR equals 16'hACE1 after the edge and never reads 0 over 70000 cycles.
